// File: rtl/uart_pkg.sv
// Shared UART constants: ASCII codes, parser FSM states and a byte classifier.
// Also used by the UART TX formatter.
package uart_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SIGN   = 2'd1,
    ST_DIGITS = 2'd2,
    ST_SKIP   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_DIG = 3'd0,
    CLS_NEG = 3'd1,
    CLS_SEP = 3'd2,
    CLS_EOR = 3'd3,
    CLS_SPC = 3'd4,
    CLS_OTH = 3'd5
  } byte_cls_e;

  // Map a received byte to its parser class.
  function automatic byte_cls_e classify(input logic [7:0] b);
    if (b >= ASCII_0 && b <= ASCII_9)       return CLS_DIG;
    else if (b == ASCII_MINUS)              return CLS_NEG;
    else if (b == ASCII_COMMA)              return CLS_SEP;
    else if (b == ASCII_LF || b == ASCII_CR) return CLS_EOR;
    else if (b == ASCII_SPACE)              return CLS_SPC;
    else                                    return CLS_OTH;
  endfunction

endpackage

// File: rtl/uart_dec_accum.sv
// Decimal accumulator datapath (combinational).
//   acc_i        running unsigned magnitude
//   digit_i      next decimal digit (0-9)
//   neg_i        field carries a leading '-'
//   acc_nxt_c_o  acc*10 + digit, clamped at 2^DATA_W-1
//   data_c_o     signed sample for acc_i, clamped to the DATA_W range
//   sat_c_o      acc_i exceeded the signed limit
module uart_dec_accum #(
  parameter  int unsigned DATA_W = 16,
  localparam int unsigned ACC_W  = DATA_W + 4
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [3:0]        digit_i,
  input  logic              neg_i,
  output logic [ACC_W-1:0]  acc_nxt_c_o,
  output logic [DATA_W-1:0] data_c_o,
  output logic              sat_c_o
);

  localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {DATA_W{1'b1}}};
  localparam logic [ACC_W-1:0] POS_LIM = {5'b00000, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_LIM = {4'b0000, 1'b1, {(DATA_W-1){1'b0}}};

  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  mag;
  logic [DATA_W-1:0] mag_w;

  // acc never exceeds 2^DATA_W-1, so x10+9 always fits in DATA_W+4 bits.
  always_comb begin
    sum         = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);
    acc_nxt_c_o = (sum > ACC_MAX) ? ACC_MAX : sum;
  end

  // Clamp to the signed range, then negate; "-0" naturally becomes 0.
  always_comb begin
    if (neg_i) begin
      sat_c_o = (acc_i > NEG_LIM);
      mag     = sat_c_o ? NEG_LIM : acc_i;
    end else begin
      sat_c_o = (acc_i > POS_LIM);
      mag     = sat_c_o ? POS_LIM : acc_i;
    end
    mag_w    = mag[DATA_W-1:0];
    data_c_o = neg_i ? DATA_W'(-mag_w) : mag_w;
  end

endmodule

// File: rtl/uart_ascii_csv_parser.sv
// Parses comma-separated signed decimal records from the UART RX byte stream
// into DATA_W-bit samples with channel index, last-in-record and saturation flags.
//   clk, rst_n          clock, async active-low reset
//   rx_dv_i, rx_byte_i  received byte strobe and data
//   num_*_o / num_ready_i  sample output with valid/ready handshake
//   err_o               pulse on a malformed field or record
//   ovr_o               pulse when a completed sample is dropped (output busy)
module uart_ascii_csv_parser
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_W     = 16,
  parameter  int unsigned MAX_DIGITS = 5,
  parameter  int unsigned NUM_CH     = 4,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              num_valid_o,
  input  logic              num_ready_i,
  output logic [DATA_W-1:0] num_data_o,
  output logic [CH_W-1:0]   num_ch_o,
  output logic              num_last_o,
  output logic              num_sat_o,
  output logic              err_o,
  output logic              ovr_o
);

  localparam int unsigned ACC_W  = DATA_W + 4;
  localparam int unsigned NDIG_W = $clog2(MAX_DIGITS + 1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_src, acc_nxt;
  logic [NDIG_W-1:0] ndig_q, ndig_d;
  logic              neg_q, neg_d;
  logic              trail_q, trail_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              valid_d, last_d, sat_d, err_d, ovr_d;
  logic [DATA_W-1:0] data_d;
  logic [CH_W-1:0]   och_d;
  logic [DATA_W-1:0] smp_data;
  logic              smp_sat;
  logic              complete;
  byte_cls_e         cls;
  logic              sep_ovf;
  logic              dig_full;

  assign cls      = classify(rx_byte_i);
  assign sep_ovf  = (ch_q == CH_W'(NUM_CH - 1));
  assign dig_full = (ndig_q == NDIG_W'(MAX_DIGITS));
  // A new field always starts accumulating from zero.
  assign acc_src  = (state_q == ST_DIGITS) ? acc_q : '0;

  uart_dec_accum #(.DATA_W(DATA_W)) u_accum (
    .acc_i       (acc_src),
    .digit_i     (rx_byte_i[3:0]),
    .neg_i       (neg_q),
    .acc_nxt_c_o (acc_nxt),
    .data_c_o    (smp_data),
    .sat_c_o     (smp_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a SEP on the last channel diverts to SKIP until EOR.
  always_comb begin
    state_d = state_q;
    if (rx_dv_i) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (cls)
            CLS_DIG: state_d = ST_DIGITS;
            CLS_NEG: state_d = ST_SIGN;
            CLS_SEP: state_d = sep_ovf ? ST_SKIP : ST_IDLE;
            CLS_EOR: state_d = ST_IDLE;
            CLS_SPC: state_d = ST_IDLE;
            default: state_d = ST_SKIP;
          endcase
        end
        ST_SIGN: begin
          unique case (cls)
            CLS_DIG: state_d = ST_DIGITS;
            CLS_SEP: state_d = sep_ovf ? ST_SKIP : ST_IDLE;
            CLS_EOR: state_d = ST_IDLE;
            default: state_d = ST_SKIP;
          endcase
        end
        ST_DIGITS: begin
          unique case (cls)
            CLS_DIG: state_d = (trail_q || dig_full) ? ST_SKIP : ST_DIGITS;
            CLS_SEP: state_d = sep_ovf ? ST_SKIP : ST_IDLE;
            CLS_EOR: state_d = ST_IDLE;
            CLS_SPC: state_d = ST_DIGITS;
            default: state_d = ST_SKIP;
          endcase
        end
        default: begin
          unique case (cls)
            CLS_SEP: state_d = sep_ovf ? ST_SKIP : ST_IDLE;
            CLS_EOR: state_d = ST_IDLE;
            default: state_d = ST_SKIP;
          endcase
        end
      endcase
    end
  end

  // Datapath, channel counter and output-register next values.
  always_comb begin
    acc_d    = acc_q;
    ndig_d   = ndig_q;
    neg_d    = neg_q;
    trail_d  = trail_q;
    ch_d     = ch_q;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    complete = 1'b0;
    valid_d  = num_valid_o;
    data_d   = num_data_o;
    och_d    = num_ch_o;
    last_d   = num_last_o;
    sat_d    = num_sat_o;

    if (rx_dv_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cls == CLS_DIG) begin
            acc_d  = acc_nxt;
            ndig_d = NDIG_W'(1);
          end else if (cls == CLS_NEG) begin
            neg_d = 1'b1;
          end else if (cls == CLS_OTH) begin
            err_d = 1'b1;
          end
        end
        ST_SIGN: begin
          if (cls == CLS_DIG) begin
            acc_d  = acc_nxt;
            ndig_d = NDIG_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DIGITS: begin
          if (cls == CLS_DIG) begin
            if (trail_q || dig_full) begin
              err_d = 1'b1;
            end else begin
              acc_d  = acc_nxt;
              ndig_d = ndig_q + NDIG_W'(1);
            end
          end else if (cls == CLS_SEP || cls == CLS_EOR) begin
            complete = 1'b1;
          end else if (cls == CLS_SPC) begin
            trail_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase

      // Channel rule, common to every state.
      if (cls == CLS_SEP) begin
        if (sep_ovf) err_d = 1'b1;
        else         ch_d  = ch_q + CH_W'(1);
      end else if (cls == CLS_EOR) begin
        ch_d = '0;
      end
    end

    // Leaving the field discards the partial value.
    if (state_d == ST_IDLE || state_d == ST_SKIP) begin
      acc_d   = '0;
      ndig_d  = '0;
      neg_d   = 1'b0;
      trail_d = 1'b0;
    end

    if (num_valid_o && num_ready_i) valid_d = 1'b0;

    // Load when the register is free or being drained this cycle; else drop.
    if (complete) begin
      if (!num_valid_o || num_ready_i) begin
        valid_d = 1'b1;
        data_d  = smp_data;
        och_d   = ch_q;
        last_d  = (cls == CLS_EOR);
        sat_d   = smp_sat;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ndig_q      <= '0;
      neg_q       <= 1'b0;
      trail_q     <= 1'b0;
      ch_q        <= '0;
      num_valid_o <= 1'b0;
      num_data_o  <= '0;
      num_ch_o    <= '0;
      num_last_o  <= 1'b0;
      num_sat_o   <= 1'b0;
      err_o       <= 1'b0;
      ovr_o       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ndig_q      <= ndig_d;
      neg_q       <= neg_d;
      trail_q     <= trail_d;
      ch_q        <= ch_d;
      num_valid_o <= valid_d;
      num_data_o  <= data_d;
      num_ch_o    <= och_d;
      num_last_o  <= last_d;
      num_sat_o   <= sat_d;
      err_o       <= err_d;
      ovr_o       <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_ascii_csv_parser.sv
// Directed bench for uart_ascii_csv_parser (DATA_W=16, MAX_DIGITS=5, NUM_CH=4).
module tb_uart_ascii_csv_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        num_valid;
  logic        num_ready;
  logic [15:0] num_data;
  logic [1:0]  num_ch;
  logic        num_last;
  logic        num_sat;
  logic        err;
  logic        ovr;

  int errors  = 0;
  int checks  = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic [19:0] samples[$];

  always #5 clk = ~clk;

  uart_ascii_csv_parser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_dv_i     (rx_dv),
    .rx_byte_i   (rx_byte),
    .num_valid_o (num_valid),
    .num_ready_i (num_ready),
    .num_data_o  (num_data),
    .num_ch_o    (num_ch),
    .num_last_o  (num_last),
    .num_sat_o   (num_sat),
    .err_o       (err),
    .ovr_o       (ovr)
  );

  // Inputs change 2ns after posedge; observe on negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (num_valid && num_ready) samples.push_back({num_data, num_ch, num_last, num_sat});
      if (err) err_cnt++;
      if (ovr) ovr_cnt++;
    end
  end

  function automatic logic [19:0] pk(input logic [15:0] d, input logic [1:0] c,
                                     input logic l, input logic s);
    return {d, c, l, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_sample(input string tag, input logic [19:0] exp);
    logic [19:0] got;
    got = 'x;
    if (samples.size() > 0) got = samples.pop_front();
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Send a string; b2b=1 drives Rx_DV on consecutive cycles.
  task automatic send_str(input string s, input bit b2b);
    for (int i = 0; i < s.len(); i++) begin
      rx_dv   = 1'b1;
      rx_byte = s[i];
      tick(1);
      rx_dv = 1'b0;
      if (!b2b) tick(1);
    end
    rx_dv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick(1);
    rx_dv = 1'b0;
    tick(1);
  endtask

  int e0, o0;

  initial begin
    rst_n     = 1'b0;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    num_ready = 1'b1;
    tick(2);
    check("reset_outputs", 32'({num_valid, num_data, num_ch, num_last, num_sat, err, ovr}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: basic record
    e0 = err_cnt;
    send_str("12,-345,0,32767\n", 1'b0);
    tick(3);
    expect_sample("t1_s0", pk(16'd12, 2'd0, 1'b0, 1'b0));
    expect_sample("t1_s1", pk(16'hFEA7, 2'd1, 1'b0, 1'b0));
    expect_sample("t1_s2", pk(16'd0, 2'd2, 1'b0, 1'b0));
    expect_sample("t1_s3", pk(16'h7FFF, 2'd3, 1'b1, 1'b0));
    check("t1_no_err", 32'(err_cnt - e0), 32'd0);
    check("t1_drained", 32'(samples.size()), 32'd0);

    // 2: saturation, back-to-back bytes
    send_str("40000,-40000\n", 1'b1);
    send_str("-32768\n", 1'b1);
    tick(3);
    expect_sample("t2_pos_sat", pk(16'h7FFF, 2'd0, 1'b0, 1'b1));
    expect_sample("t2_neg_sat", pk(16'h8000, 2'd1, 1'b1, 1'b1));
    expect_sample("t2_neg_min", pk(16'h8000, 2'd0, 1'b1, 1'b0));

    // 3: malformed fields
    e0 = err_cnt;
    send_str("123456,7\n", 1'b0);
    tick(3);
    check("t3a_err", 32'(err_cnt - e0), 32'd1);
    expect_sample("t3a_s", pk(16'd7, 2'd1, 1'b1, 1'b0));
    check("t3a_only", 32'(samples.size()), 32'd0);
    e0 = err_cnt;
    send_str("1a,2\n", 1'b1);
    tick(3);
    check("t3b_err", 32'(err_cnt - e0), 32'd1);
    expect_sample("t3b_s", pk(16'd2, 2'd1, 1'b1, 1'b0));
    e0 = err_cnt;
    send_str("-,5\n", 1'b0);
    tick(3);
    check("t3c_err", 32'(err_cnt - e0), 32'd1);
    expect_sample("t3c_s", pk(16'd5, 2'd1, 1'b1, 1'b0));
    check("t3_only", 32'(samples.size()), 32'd0);

    // 4: too many fields
    e0 = err_cnt;
    send_str("1,2,3,4,5\n", 1'b0);
    send_str("6\n", 1'b0);
    tick(3);
    check("t4_err", 32'(err_cnt - e0), 32'd1);
    expect_sample("t4_s0", pk(16'd1, 2'd0, 1'b0, 1'b0));
    expect_sample("t4_s1", pk(16'd2, 2'd1, 1'b0, 1'b0));
    expect_sample("t4_s2", pk(16'd3, 2'd2, 1'b0, 1'b0));
    expect_sample("t4_s3", pk(16'd4, 2'd3, 1'b0, 1'b0));
    expect_sample("t4_next", pk(16'd6, 2'd0, 1'b1, 1'b0));
    check("t4_only", 32'(samples.size()), 32'd0);

    // 5a: output stalled -> hold and overrun
    num_ready = 1'b0;
    o0 = ovr_cnt;
    send_str("1,2\n", 1'b0);
    tick(2);
    check("t5_hold", 32'({num_valid, num_data, num_ch, num_last, num_sat}), 32'({1'b1, 16'd1, 2'd0, 1'b0, 1'b0}));
    check("t5_ovr", 32'(ovr_cnt - o0), 32'd1);
    num_ready = 1'b1;
    tick(1);
    num_ready = 1'b0;
    tick(2);
    expect_sample("t5_held_s", pk(16'd1, 2'd0, 1'b0, 1'b0));
    check("t5_cleared", 32'(num_valid), 32'd0);
    check("t5_lost", 32'(samples.size()), 32'd0);

    // 5b: ready coincides with completion -> new sample loads, no overrun
    o0 = ovr_cnt;
    send_str("3,", 1'b0);
    rx_dv   = 1'b1;
    rx_byte = 8'h34;
    tick(1);
    rx_byte   = 8'h2C;
    num_ready = 1'b1;
    tick(1);
    rx_dv     = 1'b0;
    num_ready = 1'b0;
    tick(1);
    check("t5b_load", 32'({num_valid, num_data, num_ch}), 32'({1'b1, 16'd4, 2'd1}));
    check("t5b_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    expect_sample("t5b_first", pk(16'd3, 2'd0, 1'b0, 1'b0));
    num_ready = 1'b1;
    tick(1);
    send_byte(8'h0A);
    tick(2);
    expect_sample("t5b_second", pk(16'd4, 2'd1, 1'b0, 1'b0));

    // 6: reset mid-field with a pending sample
    num_ready = 1'b0;
    send_str("8,-12", 1'b0);
    check("t6_pending", 32'(num_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_out", 32'({num_valid, num_data, num_ch, num_last, num_sat, err, ovr}), 32'd0);
    tick(2);
    rst_n     = 1'b1;
    num_ready = 1'b1;
    e0 = err_cnt;
    tick(1);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h39);
    send_byte(8'h0D);
    send_byte(8'h0A);
    tick(3);
    expect_sample("t6_nine", pk(16'd9, 2'd0, 1'b1, 1'b0));
    check("t6_one_sample", 32'(samples.size()), 32'd0);
    check("t6_no_err", 32'(err_cnt - e0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
